// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
//   Turns read-window and write-window strobes into per-cycle mode and phase codes
//   for the SRAM interface. Reads step through the half of the phase space selected by
//   column parity. Writes cycle through WR_PHASES phases, and each phase is held for
//   WR_HOLD clocks.
//   All outputs are registered from the current state, so they lag the state by one clock.
//
// Parameters
//   RD_PHASES  total read phases (even); even columns use the lower half, odd the upper
//   WR_PHASES  write phases per write cycle (1..4)
//   WR_HOLD    clocks each write phase is held (1..16)
//   RC_W       width of rdSramCount (derived)
//
// Ports
//   clk100m        system clock
//   rst_n          synchronous active-low reset
//   in_range       current pixel column inside active read window
//   col_even_odd   column parity: 0 even, 1 odd
//   inRam_wrStart  request to begin input-RAM write sequence
//   inRam_wrFinal  last write data; ends write sequence in the final write phase
//   mode           000 idle, 010 read, 1pp write phase pp
//   rdSramCount    current read phase index (held during writes)
//   wr_phase       current write phase index (0 outside write)
//   busy           sequencer not idle
//
// Build option
//   SRAM_SEQ_WRQ_EN: a write request seen during reads is queued. It is taken at the
//   next read half boundary.
module sram_access_sequencer #(
  parameter int unsigned RD_PHASES = 4,
  parameter int unsigned WR_PHASES = 2,
  parameter int unsigned WR_HOLD   = 2,
  localparam int unsigned RC_W     = $clog2(RD_PHASES)
) (
  input  logic            clk100m,
  input  logic            rst_n,
  input  logic            in_range,
  input  logic            col_even_odd,
  input  logic            inRam_wrStart,
  input  logic            inRam_wrFinal,
  output logic [2:0]      mode,
  output logic [RC_W-1:0] rdSramCount,
  output logic [1:0]      wr_phase,
  output logic            busy
);

  localparam logic [RC_W-1:0] HalfStart = RC_W'(RD_PHASES / 2);
  localparam logic [RC_W-1:0] HalfLast  = RC_W'(RD_PHASES / 2 - 1);
  localparam logic [RC_W-1:0] FullLast  = RC_W'(RD_PHASES - 1);
  localparam logic [RC_W-1:0] RdOne     = RC_W'(1);
  localparam logic [1:0]      WrLast    = 2'(WR_PHASES - 1);
  localparam logic [3:0]      HoldLast  = 4'(WR_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e          state_q, state_d;
  logic [RC_W-1:0] rd_ph_q, rd_ph_d;
  logic [1:0]      wr_ph_q, wr_ph_d;
  logic [3:0]      hold_q, hold_d;
  logic [2:0]      mode_d;
  logic [RC_W-1:0] rd_cnt_d;
  logic [1:0]      wr_phase_d;
  logic            busy_d;
  logic            rd_last;
  logic            wr_req;
  logic [RC_W-1:0] rd_restart;

`ifdef SRAM_SEQ_WRQ_EN
  logic pending_q, pending_d;
  assign wr_req = inRam_wrStart | pending_q;
`else
  assign wr_req = inRam_wrStart;
`endif

  // Every read phase that ends a half is a boundary. With RD_PHASES=2 that is every phase.
  assign rd_last    = (rd_ph_q == HalfLast) || (rd_ph_q == FullLast);
  assign rd_restart = col_even_odd ? HalfStart : '0;

  // State register
  always_ff @(posedge clk100m) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_ph_q     <= '0;
      wr_ph_q     <= '0;
      hold_q      <= '0;
      mode        <= 3'b000;
      rdSramCount <= '0;
      wr_phase    <= 2'b00;
      busy        <= 1'b0;
`ifdef SRAM_SEQ_WRQ_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ph_q     <= rd_ph_d;
      wr_ph_q     <= wr_ph_d;
      hold_q      <= hold_d;
      mode        <= mode_d;
      rdSramCount <= rd_cnt_d;
      wr_phase    <= wr_phase_d;
      busy        <= busy_d;
`ifdef SRAM_SEQ_WRQ_EN
      pending_q   <= pending_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rd_ph_d   = rd_ph_q;
    wr_ph_d   = wr_ph_q;
    hold_d    = hold_q;
`ifdef SRAM_SEQ_WRQ_EN
    pending_d = pending_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (inRam_wrFinal) begin
`ifdef SRAM_SEQ_WRQ_EN
          pending_d = 1'b0;
`endif
        end else if (wr_req) begin
          state_d   = StWr;
          wr_ph_d   = 2'b00;
          hold_d    = 4'd0;
`ifdef SRAM_SEQ_WRQ_EN
          pending_d = 1'b0;
`endif
        end else if (in_range) begin
          state_d = StRd;
          rd_ph_d = rd_restart;
        end
      end
      StRd: begin
        if (rd_last) begin
`ifdef SRAM_SEQ_WRQ_EN
          if (wr_req) begin
            state_d   = StWr;
            wr_ph_d   = 2'b00;
            hold_d    = 4'd0;
            pending_d = 1'b0;
          end else
`endif
          if (!in_range) begin
            state_d = StIdle;
          end else begin
            // Parity is only sampled here, so a mid-half change waits for the boundary.
            rd_ph_d = rd_restart;
          end
        end else begin
          rd_ph_d = rd_ph_q + RdOne;
`ifdef SRAM_SEQ_WRQ_EN
          pending_d = pending_q | inRam_wrStart;
`endif
        end
      end
      StWr: begin
        if (inRam_wrFinal && (wr_ph_q == WrLast)) begin
          state_d = StIdle;
          wr_ph_d = 2'b00;
          hold_d  = 4'd0;
        end else if (hold_q == HoldLast) begin
          hold_d  = 4'd0;
          wr_ph_d = (wr_ph_q == WrLast) ? 2'b00 : wr_ph_q + 2'd1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; the results are registered above.
  always_comb begin
    mode_d     = 3'b000;
    rd_cnt_d   = '0;
    wr_phase_d = 2'b00;
    busy_d     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRd: begin
        mode_d   = 3'b010;
        rd_cnt_d = rd_ph_q;
        busy_d   = 1'b1;
      end
      StWr: begin
        mode_d     = {1'b1, wr_ph_q};
        rd_cnt_d   = rdSramCount;
        wr_phase_d = wr_ph_q;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// tb_sram_access_sequencer
//   Directed vector bench for sram_access_sequencer with default parameters.
//   Each row gives the inputs for one clock and the outputs expected just after that edge.
module tb_sram_access_sequencer;

  logic       clk100m;
  logic       rst_n;
  logic       in_range;
  logic       col_even_odd;
  logic       inRam_wrStart;
  logic       inRam_wrFinal;
  logic [2:0] mode;
  logic [1:0] rdSramCount;
  logic [1:0] wr_phase;
  logic       busy;

  int checks;
  int errors;

  sram_access_sequencer dut (
    .clk100m      (clk100m),
    .rst_n        (rst_n),
    .in_range     (in_range),
    .col_even_odd (col_even_odd),
    .inRam_wrStart(inRam_wrStart),
    .inRam_wrFinal(inRam_wrFinal),
    .mode         (mode),
    .rdSramCount  (rdSramCount),
    .wr_phase     (wr_phase),
    .busy         (busy)
  );

  initial clk100m = 1'b0;
  always #5 clk100m = ~clk100m;

  typedef struct {
    logic       rst_n;
    logic       in_range;
    logic       par;
    logic       ws;
    logic       wf;
    logic [2:0] mode;
    logic [1:0] rc;
    logic [1:0] wp;
    logic       busy;
  } vec_t;

  vec_t vecs[36];

  function automatic vec_t mk(input logic r, input logic i, input logic p, input logic s,
                              input logic f, input logic [2:0] m, input logic [1:0] c,
                              input logic [1:0] w, input logic b);
    vec_t v;
    v.rst_n = r; v.in_range = i; v.par = p; v.ws = s; v.wf = f;
    v.mode = m;  v.rc = c;       v.wp = w;  v.busy = b;
    return v;
  endfunction

  task automatic compare(input vec_t v, input string name);
    checks++;
    if (mode !== v.mode || rdSramCount !== v.rc || wr_phase !== v.wp || busy !== v.busy) begin
      errors++;
      $display("FAIL %s: got mode=%b rc=%0d wp=%0d busy=%b, want mode=%b rc=%0d wp=%0d busy=%b",
               name, mode, rdSramCount, wr_phase, busy, v.mode, v.rc, v.wp, v.busy);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    rst_n         = v.rst_n;
    in_range      = v.in_range;
    col_even_odd  = v.par;
    inRam_wrStart = v.ws;
    inRam_wrFinal = v.wf;
    @(posedge clk100m);
    #1;
    compare(v, name);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Read, even parity, then drop in_range at phase 1
    vecs[0]  = mk(1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1);
    vecs[2]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1);
    vecs[3]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1);
    vecs[4]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1);
    vecs[5]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1);
    vecs[6]  = mk(1, 0, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1);
    vecs[7]  = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    // Odd parity start, flip to even mid-half: 2,3,0,1
    vecs[8]  = mk(1, 1, 1, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 0, 3'b010, 2'd2, 2'd0, 1);
    vecs[10] = mk(1, 1, 0, 0, 0, 3'b010, 2'd3, 2'd0, 1);
    vecs[11] = mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1);
    vecs[13] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    // Write sequence; wrFinal ignored in phase 0, honoured in phase 1
    vecs[14] = mk(1, 0, 0, 1, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 1);
    vecs[16] = mk(1, 0, 0, 0, 1, 3'b100, 2'd0, 2'd0, 1);
    vecs[17] = mk(1, 0, 0, 0, 0, 3'b101, 2'd0, 2'd1, 1);
    vecs[18] = mk(1, 0, 0, 0, 0, 3'b101, 2'd0, 2'd1, 1);
    vecs[19] = mk(1, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 1);
    vecs[20] = mk(1, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 1);
    vecs[21] = mk(1, 0, 0, 0, 1, 3'b101, 2'd0, 2'd1, 1);
    vecs[22] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    // wrFinal has priority in IDLE over wrStart and in_range
    vecs[23] = mk(1, 0, 0, 1, 1, 3'b000, 2'd0, 2'd0, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[25] = mk(1, 1, 0, 0, 1, 3'b000, 2'd0, 2'd0, 0);
    vecs[26] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    // wrStart beats in_range; quick exit at first phase-1 cycle
    vecs[27] = mk(1, 1, 0, 1, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[28] = mk(1, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 1);
    vecs[29] = mk(1, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 1);
    vecs[30] = mk(1, 0, 0, 0, 1, 3'b101, 2'd0, 2'd1, 1);
    vecs[31] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    // Reset mid-read
    vecs[32] = mk(1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[33] = mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1);
    vecs[34] = mk(0, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);
    vecs[35] = mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0);

    // Reset held two clocks with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_range      = 1'($urandom);
      col_even_odd  = 1'($urandom);
      inRam_wrStart = 1'($urandom);
      inRam_wrFinal = 1'($urandom);
      @(posedge clk100m);
      #1;
    end
    compare(mk(0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0), "reset_held");
    step(mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0), "reset_release");

    for (int i = 0; i < 36; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Write request during reads
    step(mk(1, 1, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0), "wrq_a");
    step(mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1), "wrq_b");
    step(mk(1, 1, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1), "wrq_c");
    step(mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1), "wrq_d");
    step(mk(1, 1, 0, 1, 0, 3'b010, 2'd1, 2'd0, 1), "wrq_e");
`ifdef SRAM_SEQ_WRQ_EN
    step(mk(1, 1, 0, 0, 0, 3'b100, 2'd1, 2'd0, 1), "wrq_f");
    step(mk(1, 1, 0, 0, 0, 3'b100, 2'd1, 2'd0, 1), "wrq_g");
    step(mk(1, 0, 0, 0, 1, 3'b101, 2'd1, 2'd1, 1), "wrq_h");
    step(mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0), "wrq_i");
`else
    step(mk(1, 1, 0, 0, 0, 3'b010, 2'd0, 2'd0, 1), "wrq_f");
    step(mk(1, 0, 0, 0, 0, 3'b010, 2'd1, 2'd0, 1), "wrq_g");
    step(mk(1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0, 0), "wrq_h");
    step(mk(1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 0), "wrq_i");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
